// File: rtl/spy_capture_buffer.sv
// spy_capture_buffer: trigger-based circular capture of the algorithm output.
// Samples are written into a DEPTH-entry ring while armed. A trigger starts a
// post-trigger count, and after post_len further samples the ring freezes so
// software can read the window back, oldest sample first.
//
// Read handshake: rd_en in cycle n is a read request. rd_data is qualified by
// rd_valid in cycle n+1. There is no backpressure, so reads can be issued every
// cycle. rd_valid is low in any cycle that follows a cycle without rd_en.
//
// dbg_state encoding: 0 = IDLE, 1 = ARMED, 2 = POST, 3 = DONE.
module spy_capture_buffer #(
  parameter int DW = 36,
  parameter int AW = 8
) (
  input  logic          clk40,
  input  logic          m_aresetn,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          arm,
  input  logic          trig,
  input  logic [AW-1:0] post_len,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_ptr,
  output logic          wrapped,
  output logic [AW:0]   fill_cnt,
  output logic [1:0]    dbg_state
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            wrapped_q, wrapped_d;
  logic [AW-1:0]   trig_ptr_q, trig_ptr_d;
  logic [AW-1:0]   post_cnt_q, post_cnt_d;
  logic            wr_en;

  logic [DW-1:0]   rd_data_q;
  logic            rd_valid_q;
  logic [AW-1:0]   rd_oldest;
  logic [AW-1:0]   rd_phys;

  logic [DW-1:0]   mem [DEPTH];

  // Capture control: arm wins over everything, then per-state behaviour.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wrapped_d  = wrapped_q;
    trig_ptr_d = trig_ptr_q;
    post_cnt_d = post_cnt_q;
    wr_en      = 1'b0;

    if (arm) begin
      // Restart: the din of this cycle is not stored and any trig is dropped.
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      wrapped_d  = 1'b0;
      trig_ptr_d = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          wr_en = din_valid;
          if (trig) begin
            // The slot at wr_ptr is the trigger sample, whether it is written
            // now or by the next valid word.
            state_d    = S_POST;
            trig_ptr_d = wr_ptr_q;
            post_cnt_d = post_len;
          end
        end
        S_POST: begin
          if (post_cnt_q == '0) begin
            state_d = S_DONE;
          end else if (din_valid) begin
            wr_en      = 1'b1;
            post_cnt_d = post_cnt_q - AW'(1);
          end
        end
        S_IDLE:  state_d = S_IDLE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase

      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (wr_ptr_q == {AW{1'b1}}) begin
          wrapped_d = 1'b1;
        end
      end
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk40) begin
    if (!m_aresetn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      wrapped_q  <= 1'b0;
      trig_ptr_q <= '0;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wrapped_q  <= wrapped_d;
      trig_ptr_q <= trig_ptr_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  // Ring storage; contents survive reset, but no write happens while in reset.
  always_ff @(posedge clk40) begin
    if (wr_en && m_aresetn) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Readout is relative to the oldest stored sample.
  always_comb begin
    rd_oldest = wrapped_q ? wr_ptr_q : '0;
    rd_phys   = rd_oldest + rd_addr;
  end

  // One-cycle registered read port.
  always_ff @(posedge clk40) begin
    if (!m_aresetn) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= mem[rd_phys];
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = (state_q == S_ARMED) || (state_q == S_POST);
  assign done      = (state_q == S_DONE);
  assign trig_ptr  = trig_ptr_q;
  assign wrapped   = wrapped_q;
  assign fill_cnt  = wrapped_q ? {1'b1, {AW{1'b0}}} : {1'b0, wr_ptr_q};
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spy_capture_buffer.sv
// Bench for spy_capture_buffer: directed scenarios plus randomized captures,
// checked against a sample-history model and a read-data scoreboard.
module tb_spy_capture_buffer;

  localparam int DW    = 36;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  // Model modes named after the capture phases.
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_POST  = 2;
  localparam int M_DONE  = 3;

  logic          clk40 = 1'b0;
  logic          m_aresetn = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          arm = 1'b0;
  logic          trig = 1'b0;
  logic [AW-1:0] post_len = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_ptr;
  logic          wrapped;
  logic [AW:0]   fill_cnt;
  logic [1:0]    dbg_state;

  spy_capture_buffer #(.DW(DW), .AW(AW)) dut (
    .clk40     (clk40),
    .m_aresetn (m_aresetn),
    .din       (din),
    .din_valid (din_valid),
    .arm       (arm),
    .trig      (trig),
    .post_len  (post_len),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done),
    .trig_ptr  (trig_ptr),
    .wrapped   (wrapped),
    .fill_cnt  (fill_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk40 = ~clk40;

  // ---------------- counters and scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  // Reference model: every sample stored since arm, in arrival order.
  logic [DW-1:0] m_hist[$];
  int m_mode = M_IDLE;
  int m_trig = 0;
  int m_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int m_fill();
    return (m_hist.size() >= DEPTH) ? DEPTH : m_hist.size();
  endfunction

  function automatic logic [DW-1:0] m_read(input int addr);
    int n;
    n = m_hist.size();
    return m_hist[n - m_fill() + addr];
  endfunction

  // Apply one clock cycle of inputs to the model (state after the edge).
  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic a,
                            input logic t, input logic [AW-1:0] pl,
                            input logic re, input logic [AW-1:0] ra);
    if (re) exp_q.push_back(m_read(int'(ra)));
    if (a) begin
      m_mode = M_ARMED;
      m_hist.delete();
      m_trig = 0;
    end else if (m_mode == M_ARMED) begin
      if (t) begin
        m_mode = M_POST;
        m_trig = m_hist.size() % DEPTH;
        m_left = int'(pl);
      end
      if (v) m_hist.push_back(d);
    end else if (m_mode == M_POST) begin
      if (m_left == 0) m_mode = M_DONE;
      else if (v) begin
        m_hist.push_back(d);
        m_left--;
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"},     busy,     64'(m_mode == M_ARMED || m_mode == M_POST));
    check({tag, "_done"},     done,     64'(m_mode == M_DONE));
    check({tag, "_wrapped"},  wrapped,  64'(m_hist.size() >= DEPTH));
    check({tag, "_fill_cnt"}, fill_cnt, 64'(m_fill()));
    check({tag, "_trig_ptr"}, trig_ptr, 64'(m_trig));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic a,
                     input logic t, input logic [AW-1:0] pl,
                     input logic re, input logic [AW-1:0] ra, input string tag);
    din_valid = v;  din = d;  arm = a;  trig = t;  post_len = pl;
    rd_en = re;  rd_addr = ra;
    model_step(v, d, a, t, pl, re, ra);
    @(posedge clk40);
    #1;
    check_status(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, tag);
  endtask

  task automatic do_reset();
    m_aresetn = 1'b0;
    din_valid = 1'b0;  arm = 1'b0;  trig = 1'b0;  rd_en = 1'b0;
    m_mode = M_IDLE;  m_hist.delete();  m_trig = 0;  m_left = 0;
    @(posedge clk40);
    #1;
    m_aresetn = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    w = {4'($urandom), 32'($urandom)};
    return w;
  endfunction

  // Read back the whole frozen window in order, with random gaps.
  task automatic read_window(input string tag);
    int f;
    f = m_fill();
    for (int i = 0; i < f; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, AW'(i), tag);
      if ($urandom_range(0, 3) == 0) idle(1, tag);
    end
    idle(2, tag);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk40) begin
    if (m_aresetn && rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected_valid", rd_valid, 64'd0);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("rd_data", rd_data, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    int npre;
    int got;

    do_reset();
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_state", dbg_state, 0);
    check_status("rst");

    // Basic capture: samples 0..8, trigger with sample 5, three more.
    cyc(1'b1, 36'd77, 1'b1, 1'b0, '0, 1'b0, '0, "t1_arm");
    for (int i = 0; i < 9; i++)
      cyc(1'b1, DW'(i), 1'b0, (i == 5), 8'd3, 1'b0, '0, "t1_cap");
    idle(1, "t1_end");
    check("t1_done", done, 1);
    check("t1_trig_ptr", trig_ptr, 5);
    check("t1_fill_cnt", fill_cnt, 9);
    check("t1_wrapped", wrapped, 0);
    read_window("t1_rd");

    // Back-to-back reads: four in a row, then a gap.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, AW'(i), "t6_rd");
      check("t6_rd_valid_hi", rd_valid, 1);
    end
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, "t6_gap");
    check("t6_rd_valid_lo", rd_valid, 0);

    // Wrap-around: 300 samples, trigger on the last, post_len 0.
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0, "t2_arm");
    for (int i = 0; i < 300; i++)
      cyc(1'b1, DW'(i), 1'b0, (i == 299), 8'd0, 1'b0, '0, "t2_cap");
    check("t2_done_not_yet", done, 0);
    idle(1, "t2_end");
    check("t2_done", done, 1);
    check("t2_wrapped", wrapped, 1);
    check("t2_fill_cnt", fill_cnt, 256);
    check("t2_trig_ptr", trig_ptr, 43);
    exp_q.push_back(36'd44);
    din_valid = 1'b0; arm = 1'b0; trig = 1'b0; rd_en = 1'b1; rd_addr = 8'd0;
    @(posedge clk40); #1;
    exp_q.push_back(36'd299);
    rd_addr = 8'd255;
    @(posedge clk40); #1;
    rd_en = 1'b0;
    idle(2, "t2_rd");
    read_window("t2_rdall");

    // Valid gaps after the trigger, post_len 4.
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0, "t3_arm");
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_word(), 1'b0, 1'b0, '0, 1'b0, '0, "t3_pre");
    cyc(1'b1, rnd_word(), 1'b0, 1'b1, 8'd4, 1'b0, '0, "t3_trig");
    for (int k = 0; k < 7; k++)
      cyc((k % 2) == 0, rnd_word(), 1'b0, 1'b0, '0, 1'b0, '0, "t3_post");
    check("t3_done_after_4th", done, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, "t3_fin");
    check("t3_done", done, 1);
    check("t3_span", 64'(fill_cnt) - 64'(trig_ptr), 5);
    read_window("t3_rd");

    // Event priority.
    do_reset();
    cyc(1'b1, rnd_word(), 1'b0, 1'b1, 8'd2, 1'b0, '0, "t4_idle_trig");
    check("t4_idle_state", dbg_state, 0);
    check("t4_idle_busy", busy, 0);
    cyc(1'b1, rnd_word(), 1'b1, 1'b1, 8'd2, 1'b0, '0, "t4_arm_trig");
    check("t4_armtrig_state", dbg_state, 1);
    check("t4_armtrig_ptr", trig_ptr, 0);
    cyc(1'b1, rnd_word(), 1'b0, 1'b0, '0, 1'b0, '0, "t4_after");
    check("t4_no_post", dbg_state, 1);
    cyc(1'b1, rnd_word(), 1'b0, 1'b1, 8'd50, 1'b0, '0, "t4_trig");
    cyc(1'b1, rnd_word(), 1'b0, 1'b0, '0, 1'b0, '0, "t4_post");
    check("t4_in_post", dbg_state, 2);
    cyc(1'b1, rnd_word(), 1'b1, 1'b0, '0, 1'b0, '0, "t4_rearm");
    check("t4_rearm_state", dbg_state, 1);
    check("t4_rearm_fill", fill_cnt, 0);

    // Reset in the middle of POST.
    cyc(1'b1, rnd_word(), 1'b0, 1'b0, '0, 1'b0, '0, "t5_pre");
    cyc(1'b1, rnd_word(), 1'b0, 1'b1, 8'd50, 1'b0, '0, "t5_trig");
    cyc(1'b1, rnd_word(), 1'b0, 1'b0, '0, 1'b1, 8'd0, "t5_post");
    idle(1, "t5_post2");
    do_reset();
    check("t5_state", dbg_state, 0);
    check("t5_rd_data", rd_data, 0);
    check("t5_rd_valid", rd_valid, 0);
    check_status("t5_rst");
    cyc(1'b1, rnd_word(), 1'b0, 1'b1, 8'd1, 1'b0, '0, "t5_trig_ign");
    check("t5_trig_ign_state", dbg_state, 0);

    // Randomized captures with gaps, stray triggers and varied lengths.
    for (int it = 0; it < 8; it++) begin
      cyc($urandom_range(0, 1), rnd_word(), 1'b1, $urandom_range(0, 1), 8'($urandom),
          1'b0, '0, "rnd_arm");
      npre = (it % 3 == 0) ? $urandom_range(250, 420) : $urandom_range(0, 60);
      got = 0;
      while (got < npre) begin
        logic v;
        v = ($urandom_range(0, 3) != 0);
        cyc(v, rnd_word(), 1'b0, 1'b0, 8'($urandom), 1'b0, '0, "rnd_pre");
        if (v) got++;
      end
      cyc($urandom_range(0, 1), rnd_word(), 1'b0, 1'b1,
          (it % 4 == 1) ? 8'd0 : 8'($urandom_range(0, 60)), 1'b0, '0, "rnd_trig");
      budget = 0;
      while (m_mode != M_DONE && budget < 2000) begin
        cyc($urandom_range(0, 1), rnd_word(), 1'b0, ($urandom_range(0, 7) == 0),
            8'($urandom), 1'b0, '0, "rnd_post");
        budget++;
      end
      check("rnd_done_in_budget", done, 1);
      for (int j = 0; j < 3; j++)
        cyc($urandom_range(0, 1), rnd_word(), 1'b0, $urandom_range(0, 1), 8'($urandom),
            1'b0, '0, "rnd_frozen");
      read_window("rnd_rd");
    end

    idle(3, "drain");
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit in case the stimulus stalls.
  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
